axis_rx_fifo_wr_control: RTL and testbench

AXIS_RX_FIFO_WR_CONTROL -- requirements
Module: axis_rx_fifo_wr_control

---
 rtl/axis_rx_fifo_wr_control_if.sv | 23 ++
 rtl/axis_rx_fifo_wr_control.sv | 113 +++++++++++
 tb/tb_axis_rx_fifo_wr_control.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_rx_fifo_wr_control_if.sv
// RX stream beat inputs plus the FIFO write/read handshake between the
// frame-admission controller (slave) and its environment (master).
interface axis_rx_fifo_wr_control_if #(
    parameter int CNT_WIDTH = 10
);
    logic                 s_axis_tvalid;
    logic                 s_axis_tlast;
    logic [CNT_WIDTH-1:0] fifo_wr_count;
    logic                 rd_tlast_done;
    logic                 fifo_wr_enable;
    logic                 fifo_wr_tlast;
    logic                 fifo_rd_enable;

    modport master (
        output s_axis_tvalid, s_axis_tlast, fifo_wr_count, rd_tlast_done,
        input  fifo_wr_enable, fifo_wr_tlast, fifo_rd_enable
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tlast, fifo_wr_count, rd_tlast_done,
        output fifo_wr_enable, fifo_wr_tlast, fifo_rd_enable
    );
endinterface

// File: rtl/axis_rx_fifo_wr_control.sv
// Admits whole RX frames into the FIFO only when worst-case space is free, truncates oversize frames.
// Zero-latency write strobe; no backpressure upstream, so rejected frames are discarded to TLAST.
// Read side is released one complete frame at a time via a registered enable.
module axis_rx_fifo_wr_control #(
    parameter int FIFO_DEPTH      = 512,
    parameter int CNT_WIDTH       = 10,
    parameter int MAX_FRAME_WORDS = 256
) (
    input  logic                            clk,
    input  logic                            aresetn,
    axis_rx_fifo_wr_control_if.slave        bus,
    input  logic                            gt_rx_active,
    output logic                            frame_avail,
    output logic [15:0]                     drop_count,
    output logic                            oversize_err
);
    localparam int BW = $clog2(MAX_FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t               state_q;
    logic [BW-1:0]        beat_cnt_q;
    logic [15:0]          drop_count_q;
    logic                 oversize_q;
    logic [CNT_WIDTH-1:0] stored_q, stored_d;
    logic                 frame_avail_q;
    logic                 rd_en_q, rd_en_d;

    int   free_words;
    logic accept, last_slot, wr_en, trunc, wr_tlast, drop_evt, inc, dec;

    always_comb begin
        free_words = FIFO_DEPTH - int'(bus.fifo_wr_count);
        accept     = gt_rx_active && (free_words >= MAX_FRAME_WORDS);
        // The beat in flight is the last one that still fits the reservation.
        last_slot  = (state_q == IDLE) ? (MAX_FRAME_WORDS == 1)
                                       : (beat_cnt_q == BW'(MAX_FRAME_WORDS - 1));
        wr_en      = aresetn && bus.s_axis_tvalid &&
                     ((state_q == PASS) || ((state_q == IDLE) && accept));
        trunc      = wr_en && !bus.s_axis_tlast && last_slot;
        wr_tlast   = wr_en && (bus.s_axis_tlast || trunc);
        drop_evt   = aresetn && bus.s_axis_tvalid && (state_q == IDLE) && !accept;

        inc = wr_tlast;
        dec = bus.rd_tlast_done && (stored_q != '0);
        stored_d = stored_q;
        if (inc && !dec)
            stored_d = stored_q + 1'b1;
        else if (dec && !inc)
            stored_d = stored_q - 1'b1;

        rd_en_d = rd_en_q ? !bus.rd_tlast_done : (stored_q != '0);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            drop_count_q <= '0;
            oversize_q   <= 1'b0;
        end else begin
            if (drop_evt && (drop_count_q != 16'hFFFF))
                drop_count_q <= drop_count_q + 16'd1;
            if (trunc)
                oversize_q <= 1'b1;
            if (bus.s_axis_tvalid) begin
                unique case (state_q)
                    IDLE: begin
                        if (!bus.s_axis_tlast) begin
                            state_q    <= (accept && !trunc) ? PASS : DROP;
                            beat_cnt_q <= (accept && !trunc) ? BW'(1) : '0;
                        end
                    end
                    PASS: begin
                        if (bus.s_axis_tlast || trunc) begin
                            state_q    <= bus.s_axis_tlast ? IDLE : DROP;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                    DROP: begin
                        if (bus.s_axis_tlast)
                            state_q <= IDLE;
                    end
                    default: begin
                        state_q    <= IDLE;
                        beat_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stored_q      <= '0;
            frame_avail_q <= 1'b0;
            rd_en_q       <= 1'b0;
        end else begin
            stored_q      <= stored_d;
            frame_avail_q <= (stored_d != '0);
            rd_en_q       <= rd_en_d;
        end
    end

    assign bus.fifo_wr_enable = wr_en;
    assign bus.fifo_wr_tlast  = wr_tlast;
    assign bus.fifo_rd_enable = rd_en_q;
    assign frame_avail        = frame_avail_q;
    assign drop_count         = drop_count_q;
    assign oversize_err       = oversize_q;
endmodule

// File: tb/tb_axis_rx_fifo_wr_control.sv
// Directed bench for the RX frame-admission controller: admission, drop,
// truncation, frame accounting, read-enable sequencing and async reset.
module tb_axis_rx_fifo_wr_control;
    logic        clk;
    logic        aresetn;
    logic        gt_rx_active;
    logic        frame_avail;
    logic [15:0] drop_count;
    logic        oversize_err;

    int n_pass  = 0;
    int n_total = 0;
    int strobes, tlast_at, tlast_n;

    axis_rx_fifo_wr_control_if #(.CNT_WIDTH(10)) bus ();

    axis_rx_fifo_wr_control #(
        .FIFO_DEPTH(512), .CNT_WIDTH(10), .MAX_FRAME_WORDS(256)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .bus          (bus.slave),
        .gt_rx_active (gt_rx_active),
        .frame_avail  (frame_avail),
        .drop_count   (drop_count),
        .oversize_err (oversize_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drives an n-beat frame (one beat per cycle); gt_rx_active drops after beat gt_hold.
    task automatic run_frame(input int n, input int gt_hold,
                             output int s, output int t_at, output int t_n);
        s = 0; t_at = 0; t_n = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (i == n);
            bus.rd_tlast_done = 1'b0;
            if (i > gt_hold) gt_rx_active = 1'b0;
            #1;
            if (bus.fifo_wr_enable) s++;
            if (bus.fifo_wr_enable && bus.fifo_wr_tlast) begin
                t_n++;
                t_at = i;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.rd_tlast_done = 1'b0;
        #1;
    endtask

    task automatic pulse_rd();
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.rd_tlast_done = 1'b1;
        #1;
    endtask

    initial begin
        aresetn           = 1'b0;
        gt_rx_active      = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b0;
        bus.fifo_wr_count = 10'd0;
        bus.rd_tlast_done = 1'b0;
        #12;
        chk("rst_wr_en", bus.fifo_wr_enable, 0);
        chk("rst_wr_tlast", bus.fifo_wr_tlast, 0);
        chk("rst_rd_en", bus.fifo_rd_enable, 0);
        chk("rst_frame_avail", frame_avail, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_oversize", oversize_err, 0);
        @(negedge clk);
        aresetn = 1'b1;
        bus.s_axis_tvalid = 1'b0;

        // Accepted 10-beat frame, then one-frame drain.
        run_frame(10, 1000, strobes, tlast_at, tlast_n);
        chk("t1_strobes", strobes, 10);
        chk("t1_tlast_at", tlast_at, 10);
        chk("t1_tlast_n", tlast_n, 1);
        idle();
        chk("t1_frame_avail", frame_avail, 1);
        chk("t1_rd_en_early", bus.fifo_rd_enable, 0);
        idle();
        chk("t1_rd_en", bus.fifo_rd_enable, 1);
        pulse_rd();
        idle();
        chk("t1_rd_en_clear", bus.fifo_rd_enable, 0);
        chk("t1_avail_clear", frame_avail, 0);
        chk("t1_drop_count", drop_count, 0);

        // Insufficient free space: 512-300 = 212 < 256.
        bus.fifo_wr_count = 10'd300;
        run_frame(5, 1000, strobes, tlast_at, tlast_n);
        chk("t2_strobes", strobes, 0);
        idle();
        chk("t2_drop_count", drop_count, 1);
        chk("t2_frame_avail", frame_avail, 0);

        // Oversize frame truncated at beat 256.
        bus.fifo_wr_count = 10'd0;
        run_frame(300, 1000, strobes, tlast_at, tlast_n);
        chk("t3_strobes", strobes, 256);
        chk("t3_tlast_at", tlast_at, 256);
        chk("t3_tlast_n", tlast_n, 1);
        idle();
        chk("t3_oversize", oversize_err, 1);
        chk("t3_drop_count", drop_count, 1);
        chk("t3_frame_avail", frame_avail, 1);
        pulse_rd();
        idle();
        chk("t3_avail_clear", frame_avail, 0);

        // Single-beat frame; second write coincides with a read-side TLAST.
        run_frame(1, 1000, strobes, tlast_at, tlast_n);
        chk("t4_strobes", strobes, 1);
        chk("t4_tlast_n", tlast_n, 1);
        idle();
        chk("t4_frame_avail", frame_avail, 1);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b1;
        bus.rd_tlast_done = 1'b1;
        #1;
        chk("t4_wr2_tlast", bus.fifo_wr_tlast, 1);
        idle();
        chk("t4_avail_hold", frame_avail, 1);
        pulse_rd();
        idle();
        chk("t4_avail_one_left", frame_avail, 0);
        pulse_rd();
        idle();
        chk("t4_dec_at_zero", frame_avail, 0);
        chk("t4_oversize_sticky", oversize_err, 1);

        // Link down at SOF drops; link falling mid-frame does not.
        gt_rx_active = 1'b0;
        run_frame(3, 1000, strobes, tlast_at, tlast_n);
        chk("t5_down_strobes", strobes, 0);
        idle();
        chk("t5_drop_count", drop_count, 2);
        gt_rx_active = 1'b1;
        run_frame(4, 1, strobes, tlast_at, tlast_n);
        chk("t5_mid_strobes", strobes, 4);
        chk("t5_mid_tlast_at", tlast_at, 4);
        idle();
        chk("t5_mid_avail", frame_avail, 1);
        chk("t5_mid_drop_count", drop_count, 2);
        pulse_rd();
        idle();
        gt_rx_active = 1'b1;

        // Reset mid-frame with two frames stored.
        run_frame(1, 1000, strobes, tlast_at, tlast_n);
        run_frame(1, 1000, strobes, tlast_at, tlast_n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = 1'b0;
            #1;
        end
        chk("t6_pass_wr_en", bus.fifo_wr_enable, 1);
        chk("t6_pre_avail", frame_avail, 1);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_wr_en", bus.fifo_wr_enable, 0);
        chk("t6_rst_avail", frame_avail, 0);
        chk("t6_rst_rd_en", bus.fifo_rd_enable, 0);
        chk("t6_rst_drop", drop_count, 0);
        chk("t6_rst_oversize", oversize_err, 0);
        @(negedge clk);
        aresetn = 1'b1;
        bus.fifo_wr_count = 10'd300;
        #1;
        chk("t6_sof_reject", bus.fifo_wr_enable, 0);
        idle();
        chk("t6_sof_drop", drop_count, 1);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = 1'b1;
        #1;
        chk("t6_drop_tlast", bus.fifo_wr_enable, 0);
        bus.fifo_wr_count = 10'd0;
        run_frame(1, 1000, strobes, tlast_at, tlast_n);
        chk("t6_idle_again", strobes, 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
